multi_commit: RTL
=================

MULTI_COMMIT -- requirements
Module: multi_commit

Interface
REQ-001 Parameter XLEN, default 64: GPR and PC data width.
REQ-002 Parameter NLANE, default 2: commit/write-back lanes per cycle, range 1..4.
REQ-003 Parameter NRD, default 4: GPR read ports, range 1..8.
REQ-004 clock  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-006 rd_addr  in  NRD*5  read-port register indices, port i at bits [5i+4:5i].
REQ-007 rd_data  out  NRD*XLEN  read-port data, combinational.
REQ-008 wb_valid  in  NLANE  per-lane GPR write enable.
REQ-009 wb_addr  in  NLANE*5  per-lane destination index.
REQ-010 wb_data  in  NLANE*XLEN  per-lane write data.
REQ-011 commit  in  NLANE  per-lane instruction-retire strobe; lane 0 is the oldest.
REQ-012 commit_pc  in  NLANE*XLEN  per-lane retiring PC.
REQ-013 commit_inst  in  NLANE*32  per-lane retiring instruction word.
REQ-014 commit_irq  in  1  the oldest committing lane is an interrupt entry.
REQ-015 dt_commit  out  NLANE  registered commit mask.
REQ-016 dt_pc  out  NLANE*XLEN  registered commit_pc.
REQ-017 dt_inst  out  NLANE*32  registered commit_inst.
REQ-018 dt_irq  out  1  registered commit_irq.
REQ-019 inst_counter  out  64  total instructions retired.
REQ-020 order_err  out  1  sticky commit-ordering violation flag.

Function
REQ-021 x0: writes to index 0 are discarded; every read of index 0 returns 0, including via the bypass path.
REQ-022 Writes: at each rising edge, for every lane k with wb_valid[k]=1 and wb_addr[k]!=0, the register at wb_addr[k] takes wb_data[k].
REQ-023 Same-cycle address collision: if several lanes write one index, the highest-numbered (youngest) lane wins.
REQ-024 Read bypass: rd_data[i] returns the wb_data of the highest-numbered lane with wb_valid=1 and wb_addr equal to a nonzero rd_addr[i]; with no such lane it returns the stored value.
REQ-025 Read latency is zero cycles; write-to-stored-read latency is one cycle.
REQ-026 inst_counter increments by popcount(commit) each cycle, wraps modulo 2^64, and is visible one cycle after the commit.
REQ-027 dt_commit, dt_pc, dt_inst and dt_irq register their inputs every cycle, giving one-cycle latency; dt_pc and dt_inst lanes whose commit bit was 0 hold their previous value.
REQ-028 Ordering rule: commit must be a contiguous mask from lane 0 (commit[k]=1 requires commit[k-1]=1).
REQ-029 A violation of REQ-028 sets order_err at the next edge; order_err stays set until reset.
REQ-030 A non-contiguous mask is still counted and captured exactly as presented; it is not masked.
REQ-031 commit_irq with commit[0]=0 is a violation handled as in REQ-029.
REQ-032 wb_valid and commit are independent: a lane may commit without writing a GPR, and a GPR write does not increment the counter.

Reset
REQ-033 While reset=0, GPRs 1..31, inst_counter, dt_pc and dt_inst are 0 and dt_commit, dt_irq and order_err are 0, asynchronously.
REQ-034 Writes and commits presented while reset=0 are discarded; deassertion is synchronised externally and the first update occurs at the first rising edge with reset=1.
REQ-035 rd_data reflects the reset GPR values (0) during reset, except for bypassed inputs.

Structure
REQ-036 Package multi_commit_pkg holds XLEN, the NLANE and NRD defaults, REG_AW=5, NREG=32 and a popcount function.
REQ-037 Sub-module mc_regfile (parametrised NLANE write ports and NRD read ports, with priority write and bypass) holds the GPR array; multi_commit adds the counter, the difftest capture and the ordering check.
REQ-038 The GPR array remains a flat 32-entry XLEN array so that difftest DPI pointer export continues to work unchanged.

Verification
REQ-039 Reset: reset=0, then reset=1 -> all rd_data=0, inst_counter=0, order_err=0.
REQ-040 Collision: lane0 writes x5=0x11 and lane1 writes x5=0x22 in one cycle -> same-cycle rd_addr=5 reads 0x22; next cycle the stored value reads 0x22.
REQ-041 x0: lane1 writes x0=0xFFFF, then rd_addr=0 -> 0 both in the same cycle and after.
REQ-042 Counter: commit=11 for 3 cycles, then 01 -> inst_counter reads 2, 4, 6, 7; dt_commit lags by one cycle.
REQ-043 Order: commit=10 for one cycle -> order_err=1 next cycle and held; inst_counter still +1.
REQ-044 Reset mid-run: pull reset=0 between clock edges with inst_counter=9 -> inst_counter=0 immediately, before the next edge.

Source files
------------

// File: rtl/multi_commit_pkg.sv
// Shared constants and helpers for the multi-lane commit / GPR write-back block.
package multi_commit_pkg;
  localparam int XLEN      = 64;
  localparam int NLANE_DEF = 2;
  localparam int NRD_DEF   = 4;
  localparam int REG_AW    = 5;
  localparam int NREG      = 32;
  localparam int MAX_LANE  = 4;

  // Number of set bits in a commit mask of up to MAX_LANE lanes.
  function automatic logic [2:0] popcount(input logic [MAX_LANE-1:0] mask);
    logic [2:0] n;
    n = '0;
    for (int k = 0; k < MAX_LANE; k++) n = n + 3'(mask[k]);
    return n;
  endfunction
endpackage

// File: rtl/mc_regfile.sv
// 32 x XLEN GPR file: NLANE priority write ports (youngest lane wins), NRD
// combinational read ports with write-data bypass; x0 is hardwired to zero.
module mc_regfile #(
  parameter int XLEN  = multi_commit_pkg::XLEN,
  parameter int NLANE = multi_commit_pkg::NLANE_DEF,
  parameter int NRD   = multi_commit_pkg::NRD_DEF
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [NRD*multi_commit_pkg::REG_AW-1:0]    i_rd_addr,
  output logic [NRD*XLEN-1:0]                        o_rd_data,
  input  logic [NLANE-1:0]                           i_wb_valid,
  input  logic [NLANE*multi_commit_pkg::REG_AW-1:0]  i_wb_addr,
  input  logic [NLANE*XLEN-1:0]                      i_wb_data
);
  import multi_commit_pkg::*;

  // Flat array so the difftest pointer export can see it directly.
  logic [XLEN-1:0] r_gpr [NREG];

  // NOTE: the whole array is asynchronously reset because every GPR must read
  // 0 while reset is held; index 0 is never written, so it stays 0 forever.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_gpr[i] <= '0;
    end else begin
      // NOTE: non-blocking writes issued in ascending lane order, so on an
      // address collision the last (youngest) lane's write is the one kept.
      for (int k = 0; k < NLANE; k++) begin
        if (i_wb_valid[k] && (i_wb_addr[k*REG_AW +: REG_AW] != '0))
          r_gpr[i_wb_addr[k*REG_AW +: REG_AW]] <= i_wb_data[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    logic [REG_AW-1:0] w_addr;
    logic [XLEN-1:0]   w_data;
    o_rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      w_addr = i_rd_addr[i*REG_AW +: REG_AW];
      w_data = r_gpr[w_addr];
      for (int k = 0; k < NLANE; k++) begin
        if (i_wb_valid[k] && (w_addr != '0) &&
            (i_wb_addr[k*REG_AW +: REG_AW] == w_addr))
          w_data = i_wb_data[k*XLEN +: XLEN];
      end
      o_rd_data[i*XLEN +: XLEN] = w_data;
    end
  end
endmodule

// File: rtl/multi_commit.sv
// Commit stage top: GPR file, retired-instruction counter, difftest capture
// registers and a sticky commit-ordering checker.
module multi_commit #(
  parameter int XLEN  = multi_commit_pkg::XLEN,
  parameter int NLANE = multi_commit_pkg::NLANE_DEF,
  parameter int NRD   = multi_commit_pkg::NRD_DEF
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [NRD*multi_commit_pkg::REG_AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]                        rd_data,
  input  logic [NLANE-1:0]                           wb_valid,
  input  logic [NLANE*multi_commit_pkg::REG_AW-1:0]  wb_addr,
  input  logic [NLANE*XLEN-1:0]                      wb_data,
  input  logic [NLANE-1:0]                           commit,
  input  logic [NLANE*XLEN-1:0]                      commit_pc,
  input  logic [NLANE*32-1:0]                        commit_inst,
  input  logic                                       commit_irq,
  output logic [NLANE-1:0]                           dt_commit,
  output logic [NLANE*XLEN-1:0]                      dt_pc,
  output logic [NLANE*32-1:0]                        dt_inst,
  output logic                                       dt_irq,
  output logic [63:0]                                inst_counter,
  output logic                                       order_err
);
  import multi_commit_pkg::*;

  logic [MAX_LANE-1:0]   w_mask;
  logic [2:0]            w_pop;
  logic                  w_viol;
  logic [63:0]           r_inst_cnt;
  logic [NLANE-1:0]      r_dt_commit;
  logic [NLANE*XLEN-1:0] r_dt_pc;
  logic [NLANE*32-1:0]   r_dt_inst;
  logic                  r_dt_irq;
  logic                  r_order_err;

  mc_regfile #(.XLEN(XLEN), .NLANE(NLANE), .NRD(NRD)) u_regfile (
    .clock      (clock),
    .reset      (reset),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .i_wb_valid (wb_valid),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_data)
  );

  // Commit must be a run of ones from lane 0; an irq needs lane 0 committing.
  always_comb begin
    w_mask              = '0;
    w_mask[NLANE-1:0]   = commit;
    w_pop               = popcount(w_mask);
    w_viol              = commit_irq & ~commit[0];
    for (int k = 1; k < NLANE; k++) begin
      if (commit[k] && !commit[k-1]) w_viol = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_inst_cnt  <= '0;
      r_dt_commit <= '0;
      r_dt_pc     <= '0;
      r_dt_inst   <= '0;
      r_dt_irq    <= 1'b0;
      r_order_err <= 1'b0;
    end else begin
      r_inst_cnt  <= r_inst_cnt + 64'(w_pop);
      r_dt_commit <= commit;
      r_dt_irq    <= commit_irq;
      r_order_err <= r_order_err | w_viol;
      for (int k = 0; k < NLANE; k++) begin
        if (commit[k]) begin
          r_dt_pc[k*XLEN +: XLEN] <= commit_pc[k*XLEN +: XLEN];
          r_dt_inst[k*32 +: 32]   <= commit_inst[k*32 +: 32];
        end
      end
    end
  end

  assign inst_counter = r_inst_cnt;
  assign dt_commit    = r_dt_commit;
  assign dt_pc        = r_dt_pc;
  assign dt_inst      = r_dt_inst;
  assign dt_irq       = r_dt_irq;
  assign order_err    = r_order_err;
endmodule
